gen_gamma_decoder: RTL and testbench

Receive-side counterpart of the gamma coder. It regenerates the same keystream (gamma) from a shared key using a deterministic Galois LFSR, subtracts the gamma from each received coded word `md` to recover the plaintext `id`, and flags words that cannot have come from a valid encoding. It sits between the channel receive register and the consumer, with valid/ready handshakes on both sides.

---
 rtl/gen_gamma_decoder.sv | 124 ++++++++++++
 tb/tb_gen_gamma_decoder.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/gen_gamma_decoder.sv
// gen_gamma_decoder
//   Receive-side gamma decoder. A Galois LFSR seeded from a shared key
//   regenerates the encoder's keystream. Each accepted coded word has the
//   current gamma subtracted from it to recover the plaintext. Words that
//   no valid encoding could produce are flagged with err.
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   load       key load strobe (one cycle)
//   key        LFSR seed, sampled when load=1
//   in_valid   coded word md is valid
//   in_ready   decoder accepts md this cycle
//   md         coded word, {1'b0,id}+{1'b0,gamma}
//   out_valid  id/err are valid
//   out_ready  consumer accepts the output
//   id         recovered plaintext
//   err        decode error for this word
//   gamma      current LFSR state (gamma for the next accepted word)
//   sym_cnt    words accepted since the last load
module gen_gamma_decoder #(
  parameter int              SIZE  = 8,
  parameter logic [SIZE-1:0] TAPS  = 8'hB8,
  parameter int              CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SIZE-1:0]  key,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SIZE:0]    md,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SIZE-1:0]  id,
  output logic             err,
  output logic [SIZE-1:0]  gamma,
  output logic [CNT_W-1:0] sym_cnt
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [SIZE-1:0]  LFSR_ONE = {{(SIZE-1){1'b0}}, 1'b1};
  localparam logic [SIZE+1:0]  ID_MAX   = {2'b00, {SIZE{1'b1}}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q;
  logic [SIZE-1:0]   lfsr_q;
  logic [SIZE-1:0]   id_q;
  logic              err_q;
  logic              out_valid_q;
  logic [CNT_W-1:0]  sym_cnt_q;

  logic              accept_d;
  logic [SIZE-1:0]   lfsr_d;
  logic [SIZE-1:0]   seed_d;
  logic [SIZE+1:0]   diff_d;
  logic              err_d;

  // A new word may enter when running, not loading, and the output
  // register is either empty or being drained this same cycle.
  assign in_ready = (state_q == ST_RUN) && !load && (!out_valid_q || out_ready);
  assign accept_d = in_valid && in_ready;

  // Galois step: shift right, fold taps in when the outgoing bit is 1.
  assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : '0);

  // The all-zero LFSR state is a fixed point, so a zero key maps to 1.
  assign seed_d = (key == '0) ? LFSR_ONE : key;

  // Two extra bits: one for the carry of the encoder sum, one so that an
  // underflow (md < gamma) shows up as a large value instead of aliasing.
  assign diff_d = {1'b0, md} - {2'b00, lfsr_q};
  assign err_d  = (md < {1'b0, lfsr_q}) || (diff_d > ID_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lfsr_q      <= LFSR_ONE;
      id_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      sym_cnt_q   <= '0;
    end else if (load) begin
      // Loading restarts the stream: any pending output belongs to the
      // old key and is dropped.
      state_q     <= ST_RUN;
      lfsr_q      <= seed_d;
      out_valid_q <= 1'b0;
      sym_cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          out_valid_q <= 1'b0;
        end
        ST_RUN: begin
          if (accept_d) begin
            // Replaces any output being handed off in this same edge.
            id_q        <= diff_d[SIZE-1:0];
            err_q       <= err_d;
            out_valid_q <= 1'b1;
            sym_cnt_q   <= sym_cnt_q + CNT_ONE;
            lfsr_q      <= lfsr_d;
          end else if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign id        = id_q;
  assign err       = err_q;
  assign gamma     = lfsr_q;
  assign sym_cnt   = sym_cnt_q;

endmodule

// File: tb/tb_gen_gamma_decoder.sv
// Directed testbench for gen_gamma_decoder: reset, key load, decode stream,
// error words, zero-key reload mid-stream, backpressure and mid-run reset.
module tb_gen_gamma_decoder;

  logic        clk;
  logic        rst;
  logic        load;
  logic [7:0]  key;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  md;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  id;
  logic        err;
  logic [7:0]  gamma;
  logic [15:0] sym_cnt;

  int total = 0;
  int bad   = 0;

  gen_gamma_decoder #(.SIZE(8), .TAPS(8'hB8), .CNT_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .key       (key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .md        (md),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .id        (id),
    .err       (err),
    .gamma     (gamma),
    .sym_cnt   (sym_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Advance one clock edge; outputs are sampled 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check registered outputs after an accept.
  task automatic chk_out(input string tag, input logic [7:0] e_id, input logic e_err,
                         input logic [7:0] e_gamma, input logic [15:0] e_cnt);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(1));
    chk({tag, ".id"},        32'(id),        32'(e_id));
    chk({tag, ".err"},       32'(err),       32'(e_err));
    chk({tag, ".gamma"},     32'(gamma),     32'(e_gamma));
    chk({tag, ".sym_cnt"},   32'(sym_cnt),   32'(e_cnt));
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; key = 8'h00;
    in_valid = 1'b0; md = 9'h000; out_ready = 1'b1;

    // Reset for two cycles
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst.in_ready",  32'(in_ready),  32'(0));
    chk("rst.out_valid", 32'(out_valid), 32'(0));
    chk("rst.id",        32'(id),        32'(0));
    chk("rst.err",       32'(err),       32'(0));
    chk("rst.sym_cnt",   32'(sym_cnt),   32'(0));
    chk("rst.gamma",     32'(gamma),     32'(8'h01));

    // Load key 01; word presented during load must be refused
    tick();
    load = 1'b1; key = 8'h01; in_valid = 1'b1; md = 9'h043;
    #1;
    chk("load1.in_ready", 32'(in_ready), 32'(0));
    tick();
    load = 1'b0;
    #1;
    chk("load1.gamma",    32'(gamma),     32'(8'h01));
    chk("load1.sym_cnt",  32'(sym_cnt),   32'(0));
    chk("load1.out_valid",32'(out_valid), 32'(0));
    chk("w1.in_ready",    32'(in_ready),  32'(1));
    tick();
    chk_out("w1", 8'h42, 1'b0, 8'hB8, 16'd1);
    md = 9'h0FA;
    tick();
    chk_out("w2", 8'h42, 1'b0, 8'h5C, 16'd2);

    // Error words: underflow, then overflow past 255
    md = 9'h05B;
    tick();
    chk_out("e1", 8'hFF, 1'b1, 8'h2E, 16'd3);
    md = 9'h1FF;
    tick();
    chk_out("e2", 8'hD1, 1'b1, 8'h17, 16'd4);
    in_valid = 1'b0;
    tick();
    chk("drain.out_valid", 32'(out_valid), 32'(0));

    // Zero key, one word held by backpressure, then reload
    load = 1'b1; key = 8'h00;
    tick();
    load = 1'b0;
    #1;
    chk("zkey.gamma", 32'(gamma), 32'(8'h01));
    in_valid = 1'b1; md = 9'h010; out_ready = 1'b0;
    tick();
    chk_out("zw", 8'h0F, 1'b0, 8'hB8, 16'd1);
    chk("zw.in_ready_held", 32'(in_ready), 32'(0));
    load = 1'b1; key = 8'h10;
    #1;
    chk("reload.in_ready", 32'(in_ready), 32'(0));
    tick();
    load = 1'b0;
    #1;
    chk("reload.out_valid", 32'(out_valid), 32'(0));
    chk("reload.sym_cnt",   32'(sym_cnt),   32'(0));
    chk("reload.gamma",     32'(gamma),     32'(8'h10));

    // Backpressure: one word out, then 3 stalled cycles
    out_ready = 1'b1; in_valid = 1'b1; md = 9'h020;
    tick();
    chk_out("bp0", 8'h10, 1'b0, 8'h08, 16'd1);
    out_ready = 1'b0; md = 9'h0FF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk($sformatf("bp_stall%0d.in_ready", i), 32'(in_ready), 32'(0));
      tick();
      chk_out($sformatf("bp_stall%0d", i), 8'h10, 1'b0, 8'h08, 16'd1);
    end

    // Release: four back-to-back words, one output per cycle
    out_ready = 1'b1;
    md = 9'h009; #1; chk("stream0.in_ready", 32'(in_ready), 32'(1));
    tick(); chk_out("stream0", 8'h01, 1'b0, 8'h04, 16'd2);
    md = 9'h006; #1; chk("stream1.in_ready", 32'(in_ready), 32'(1));
    tick(); chk_out("stream1", 8'h02, 1'b0, 8'h02, 16'd3);
    md = 9'h005; #1; chk("stream2.in_ready", 32'(in_ready), 32'(1));
    tick(); chk_out("stream2", 8'h03, 1'b0, 8'h01, 16'd4);
    md = 9'h005; #1; chk("stream3.in_ready", 32'(in_ready), 32'(1));
    tick(); chk_out("stream3", 8'h04, 1'b0, 8'hB8, 16'd5);

    // Reset while an output is pending
    rst = 1'b1; md = 9'h1AA;
    tick();
    rst = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(out_valid), 32'(0));
    chk("mrst.gamma",     32'(gamma),     32'(8'h01));
    chk("mrst.sym_cnt",   32'(sym_cnt),   32'(0));
    chk("mrst.id",        32'(id),        32'(0));
    chk("mrst.in_ready",  32'(in_ready),  32'(0));
    tick();
    chk("idle.out_valid", 32'(out_valid), 32'(0));
    chk("idle.gamma",     32'(gamma),     32'(8'h01));
    chk("idle.sym_cnt",   32'(sym_cnt),   32'(0));

    in_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
